// File: rtl/fifo_byte_unloader.sv
// Drains a FIFO burst and serialises each word onto a byte stream, least significant byte first.
// Define FIFO_BYTE_UNLOADER_STATS_EN to build the stall_cycles and bytes_sent counters; otherwise both ports are tied to 0.
module fifo_byte_unloader #(
  parameter int pDATA_WIDTH  = 16,
  parameter int pFWFT        = 0,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [pCOUNT_WIDTH-1:0] burst_len,
  output logic                    busy,
  output logic                    done,
  output logic                    fifo_ren,
  input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    m_valid,
  output logic [7:0]              m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             bytes_sent
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | pop next word once the FIFO is non-empty
  // WAIT  | registered-read FIFO only: capture the popped word
  // SHIFT | present hold one byte at a time
  // DONE  | one-cycle done pulse

  localparam int pBYTES = pDATA_WIDTH / 8;
  localparam int IDX_W  = (pBYTES > 1) ? $clog2(pBYTES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [pCOUNT_WIDTH-1:0] words_left, words_left_nxt;
  logic [IDX_W-1:0]        byte_idx, byte_idx_nxt;
  logic [pDATA_WIDTH-1:0]  hold, hold_nxt;
  logic                    last_byte;
  logic                    handshake;

  assign last_byte = (byte_idx == IDX_W'(pBYTES - 1));
  assign handshake = (state == S_SHIFT) && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      hold       <= '0;
    end else begin
      state      <= state_nxt;
      words_left <= words_left_nxt;
      byte_idx   <= byte_idx_nxt;
      hold       <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    words_left_nxt = words_left;
    byte_idx_nxt   = byte_idx;
    hold_nxt       = hold;
    case (state)
      S_IDLE: begin
        if (start) begin
          byte_idx_nxt = '0;
          if (burst_len == '0) begin
            state_nxt = S_DONE;
          end else begin
            words_left_nxt = burst_len;
            state_nxt      = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          if (pFWFT != 0) begin
            hold_nxt  = fifo_rdata;
            state_nxt = S_SHIFT;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        hold_nxt  = fifo_rdata;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (m_ready) begin
          if (!last_byte) begin
            byte_idx_nxt = byte_idx + 1'b1;
          end else begin
            byte_idx_nxt   = '0;
            words_left_nxt = words_left - 1'b1;
            state_nxt      = (words_left == pCOUNT_WIDTH'(1)) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort drops any partial word; a word already popped in WAIT is lost.
    if (abort && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      byte_idx_nxt = '0;
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign fifo_ren = (state == S_FETCH) && !fifo_empty;
  assign m_valid  = (state == S_SHIFT);
  assign m_data   = hold[8*byte_idx +: 8];
  assign m_last   = (state == S_SHIFT) && (words_left == pCOUNT_WIDTH'(1)) && last_byte;

`ifdef FIFO_BYTE_UNLOADER_STATS_EN
  logic [31:0] stall_q, sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      sent_q  <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_q <= '0;
      sent_q  <= '0;
    end else begin
      if ((state == S_FETCH) && fifo_empty && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (handshake && (sent_q != '1)) sent_q <= sent_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign bytes_sent   = sent_q;
`else
  assign stall_cycles = '0;
  assign bytes_sent   = '0;
`endif

endmodule

// File: tb/tb_fifo_byte_unloader.sv
// Directed bench: instance 0 uses a registered-read FIFO, instance 1 a first-word-fall-through FIFO.
// Expected bytes are queued when a burst starts and popped on each handshake.
module tb_fifo_byte_unloader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start [2];
  logic        abort [2];
  logic        m_ready [2];
  logic [15:0] burst_len [2];
  logic        busy [2];
  logic        done [2];
  logic        fifo_ren [2];
  logic        fifo_empty [2];
  logic [15:0] fifo_rdata [2];
  logic        m_valid [2];
  logic [7:0]  m_data [2];
  logic        m_last [2];
  logic [31:0] stall_cycles [2];
  logic [31:0] bytes_sent [2];

  logic [15:0] mem [2][64];
  int          wptr [2];

  for (genvar g = 0; g < 2; g++) begin : gen_u
    int          rptr;
    logic [15:0] rd_q;
    logic        underflow;

    assign fifo_empty[g] = (wptr[g] == rptr);
    assign fifo_rdata[g] = (g == 1) ? mem[g][rptr] : rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rptr      <= 0;
        rd_q      <= '0;
        underflow <= 1'b0;
      end else if (fifo_ren[g]) begin
        if (fifo_empty[g]) begin
          underflow <= 1'b1;
        end else begin
          rd_q <= mem[g][rptr];
          rptr <= rptr + 1;
        end
      end
    end

    fifo_byte_unloader #(.pDATA_WIDTH(16), .pFWFT(g), .pCOUNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]), .burst_len(burst_len[g]),
      .busy(busy[g]), .done(done[g]), .fifo_ren(fifo_ren[g]), .fifo_rdata(fifo_rdata[g]),
      .fifo_empty(fifo_empty[g]), .m_valid(m_valid[g]), .m_data(m_data[g]), .m_last(m_last[g]),
      .m_ready(m_ready[g]), .stall_cycles(stall_cycles[g]), .bytes_sent(bytes_sent[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 [2];
  int first_ren [2], first_valid [2], done_cyc [2], last_hs [2];
  int done_cnt [2], hs_cnt [2], ren_cnt [2], valid_cnt [2];
  logic ren_empty [2];
  logic prev_stall [2];
  logic [8:0] prev_byte [2];
  logic [15:0] wq0 [$], wq1 [$];
  logic [8:0]  exp0 [$], exp1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_trk(input int i);
    first_ren[i] = -1; first_valid[i] = -1; done_cyc[i] = -1; last_hs[i] = -1;
    done_cnt[i] = 0; hs_cnt[i] = 0; ren_cnt[i] = 0; valid_cnt[i] = 0;
    ren_empty[i] = 1'b0;
  endtask

  task automatic check_byte(input int i);
    logic [8:0] e;
    logic       have;
    have = (i == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
    if (!have) begin
      chk("spurious_byte", 32'(m_valid[i] && m_ready[i]), 32'd0);
    end else begin
      e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
      chk("byte_last_data", 32'({m_last[i], m_data[i]}), 32'(e));
    end
  endtask

  // Sample just after inputs settle; the following posedge sees the same values.
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (prev_stall[i]) begin
        chk("stall_valid_hold", 32'(m_valid[i]), 32'd1);
        chk("stall_byte_hold", 32'({m_last[i], m_data[i]}), 32'(prev_byte[i]));
      end
      if (fifo_ren[i]) begin
        ren_cnt[i]++;
        if (first_ren[i] < 0) first_ren[i] = cyc;
        if (fifo_empty[i]) ren_empty[i] = 1'b1;
      end
      if (m_valid[i]) begin
        valid_cnt[i]++;
        if (first_valid[i] < 0) first_valid[i] = cyc;
      end
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (m_valid[i] && m_ready[i]) begin
        check_byte(i);
        hs_cnt[i]++;
        last_hs[i] = cyc;
      end
      prev_stall[i] = m_valid[i] && !m_ready[i] && !abort[i];
      prev_byte[i]  = {m_last[i], m_data[i]};
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_word(input int i, input logic [15:0] w);
    mem[i][wptr[i]] = w;
    wptr[i]++;
    if (i == 0) wq0.push_back(w); else wq1.push_back(w);
  endtask

  task automatic start_burst(input int i, input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = (i == 0) ? wq0.pop_front() : wq1.pop_front();
      for (int b = 0; b < 2; b++) begin
        if (i == 0) exp0.push_back({(k == n - 1) && (b == 1), w[8*b +: 8]});
        else        exp1.push_back({(k == n - 1) && (b == 1), w[8*b +: 8]});
      end
    end
    clear_trk(i);
    c0[i] = cyc;
    burst_len[i] = 16'(n);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    for (int k = 0; k < 200 && done_cnt[i] == 0; k++) step();
    chk(tag, 32'(done_cnt[i] != 0), 32'd1);
    step();
    chk("done_single_pulse", 32'(done[i]), 32'd0);
    chk("busy_after_done", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; m_ready[i] = 1'b1; burst_len[i] = '0;
      wptr[i] = 0; prev_stall[i] = 1'b0; prev_byte[i] = '0; c0[i] = 0;
      clear_trk(i);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_ren", 32'(fifo_ren[i]), 32'd0);
      chk("rst_valid", 32'(m_valid[i]), 32'd0);
      chk("rst_data", 32'(m_data[i]), 32'd0);
      chk("rst_last", 32'(m_last[i]), 32'd0);
      chk("rst_stall_cnt", stall_cycles[i], 32'd0);
      chk("rst_bytes_cnt", bytes_sent[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word burst, registered-read FIFO.
    push_word(0, 16'h1234);
    push_word(0, 16'hABCD);
    start_burst(0, 2);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    wait_done(0, "t1_done_seen");
    chk("t1_ren_latency", 32'(first_ren[0] - c0[0]), 32'd1);
    chk("t1_valid_latency", 32'(first_valid[0] - c0[0]), 32'd3);
    chk("t1_done_after_last", 32'(done_cyc[0] - last_hs[0]), 32'd1);
    chk("t1_handshakes", 32'(hs_cnt[0]), 32'd4);
    chk("t1_sb_empty", 32'(exp0.size()), 32'd0);
    chk("t1_fifo_empty", 32'(fifo_empty[0]), 32'd1);

    // Zero-length burst: done only, no FIFO or stream activity.
    start_burst(0, 0);
    wait_done(0, "t2_done_seen");
    chk("t2_done_window", 32'((done_cyc[0] - c0[0] >= 1) && (done_cyc[0] - c0[0] <= 2)), 32'd1);
    chk("t2_no_ren", 32'(ren_cnt[0]), 32'd0);
    chk("t2_no_valid", 32'(valid_cnt[0]), 32'd0);

    // Three words with a toggling consumer; a start mid-burst must be ignored.
    push_word(0, 16'h5A01);
    push_word(0, 16'hC3E7);
    push_word(0, 16'h0FF0);
    m_ready[0] = 1'b1;
    start_burst(0, 3);
    for (int k = 0; k < 80 && done_cnt[0] == 0; k++) begin
      m_ready[0] = ~m_ready[0];
      start[0] = (k == 4);
      burst_len[0] = (k == 4) ? 16'd7 : 16'd3;
      step();
    end
    start[0] = 1'b0;
    m_ready[0] = 1'b1;
    chk("t3_done_seen", 32'(done_cnt[0]), 32'd1);
    chk("t3_handshakes", 32'(hs_cnt[0]), 32'd6);
    chk("t3_sb_empty", 32'(exp0.size()), 32'd0);
    step();
    step();
    chk("t3_no_restart", 32'(busy[0]), 32'd0);

    // FIFO runs dry for 20 cycles mid-burst.
    push_word(0, 16'h7788);
    push_word(0, 16'h99AA);
    mem[0][wptr[0] - 1] = 16'h0;
    wptr[0]--;
    start_burst(0, 2);
    for (int k = 0; k < 20 && hs_cnt[0] < 2; k++) step();
    chk("t4_first_word", 32'(hs_cnt[0]), 32'd2);
    repeat (20) step();
    chk("t4_idle_stream", 32'(m_valid[0]), 32'd0);
    chk("t4_still_busy", 32'(busy[0]), 32'd1);
    mem[0][wptr[0]] = 16'h99AA;
    wptr[0]++;
    wait_done(0, "t4_done_seen");
    chk("t4_no_ren_empty", 32'(ren_empty[0]), 32'd0);
    chk("t4_underflow", 32'(gen_u[0].underflow), 32'd0);
    chk("t4_sb_empty", 32'(exp0.size()), 32'd0);
`ifdef FIFO_BYTE_UNLOADER_STATS_EN
    chk("t4_stall_cycles", stall_cycles[0], 32'd20);
    chk("t4_bytes_sent", bytes_sent[0], 32'd4);
`else
    chk("t4_stall_cycles", stall_cycles[0], 32'd0);
    chk("t4_bytes_sent", bytes_sent[0], 32'd0);
`endif

    // Abort on byte 1 of word 2 of 4, then restart with start and abort together.
    push_word(0, 16'h1111);
    push_word(0, 16'h2222);
    push_word(0, 16'h3344);
    push_word(0, 16'h5566);
    start_burst(0, 4);
    for (int k = 0; k < 20 && hs_cnt[0] < 3; k++) step();
    chk("t5_pre_abort_valid", 32'(m_valid[0]), 32'd1);
    chk("t5_pre_abort_byte", 32'(m_data[0]), 32'h22);
    m_ready[0] = 1'b0;
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    m_ready[0] = 1'b1;
    chk("t5_valid_dropped", 32'(m_valid[0]), 32'd0);
    chk("t5_busy_dropped", 32'(busy[0]), 32'd0);
    chk("t5_ren_dropped", 32'(fifo_ren[0]), 32'd0);
    repeat (4) step();
    chk("t5_no_done", 32'(done_cnt[0]), 32'd0);
    exp0.delete();
    wq0.push_back(16'h3344);
    wq0.push_back(16'h5566);
    abort[0] = 1'b1;
    start_burst(0, 2);
    abort[0] = 1'b0;
    chk("t5_start_wins", 32'(busy[0]), 32'd1);
    wait_done(0, "t5_done_seen");
    chk("t5_handshakes", 32'(hs_cnt[0]), 32'd4);
    chk("t5_sb_empty", 32'(exp0.size()), 32'd0);
    chk("t5_fifo_empty", 32'(fifo_empty[0]), 32'd1);

    // First-word-fall-through FIFO: 4 words, 8 bytes in 12 cycles from the first pop.
    push_word(1, 16'hBEEF);
    push_word(1, 16'hCAFE);
    push_word(1, 16'h0102);
    push_word(1, 16'hF00D);
    start_burst(1, 4);
    wait_done(1, "t6_done_seen");
    chk("t6_ren_latency", 32'(first_ren[1] - c0[1]), 32'd1);
    chk("t6_valid_latency", 32'(first_valid[1] - c0[1]), 32'd2);
    chk("t6_span", 32'(last_hs[1] - first_ren[1] + 1), 32'd12);
    chk("t6_handshakes", 32'(hs_cnt[1]), 32'd8);
    chk("t6_sb_empty", 32'(exp1.size()), 32'd0);
`ifdef FIFO_BYTE_UNLOADER_STATS_EN
    chk("t6_bytes_sent", bytes_sent[1], 32'd8);
`else
    chk("t6_bytes_sent", bytes_sent[1], 32'd0);
`endif

    // Reset asserted mid-burst.
    push_word(0, 16'h4242);
    push_word(0, 16'h4343);
    start_burst(0, 2);
    repeat (3) step();
    chk("t7_pre_reset_valid", 32'(m_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(m_valid[0]), 32'd0);
    chk("t7_rst_busy", 32'(busy[0]), 32'd0);
    chk("t7_rst_ren", 32'(fifo_ren[0]), 32'd0);
    chk("t7_rst_data", 32'(m_data[0]), 32'd0);
    chk("t7_rst_last", 32'(m_last[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
